// File: rtl/pmem_responder.sv
// Line-granular memory model answering the cache's pmem read/write handshake.
// Each request is serviced after a fixed LATENCY and answered with a single-cycle pmem_resp.
module pmem_responder #(
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [ADDR_W-1:0] pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_resp,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              busy,
    output logic              proto_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state, state_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic               op_wr;
    logic [IDX_W-1:0]   idx;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  mem [DEPTH];

    logic               req, accept, commit, c_wr;
    logic [IDX_W-1:0]   in_idx, c_idx;
    logic [LINE_W-1:0]  c_wdata;
    logic               unused_addr;

    assign req         = pmem_read | pmem_write;
    assign in_idx      = pmem_address[5 +: IDX_W];
    assign unused_addr = ^pmem_address;
    assign pmem_resp   = (state == RESP);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // commit = the edge where the store is written or pmem_rdata is loaded
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        c_wr      = op_wr;
        c_idx     = idx;
        c_wdata   = wdata_q;
        case (state)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_nxt = 8'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // zero wait states: act on the live inputs at the accepting edge
                        state_nxt = RESP;
                        commit    = 1'b1;
                        c_wr      = pmem_write;
                        c_idx     = in_idx;
                        c_wdata   = pmem_wdata;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt == 8'd1) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr      <= 1'b0;
            idx        <= '0;
            wdata_q    <= '0;
            proto_err  <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
            pmem_rdata <= '0;
        end else begin
            if (accept) begin
                op_wr   <= pmem_write;
                idx     <= in_idx;
                wdata_q <= pmem_wdata;
                if (pmem_read && pmem_write)
                    proto_err <= 1'b1;
            end
            if (commit && !c_wr)
                pmem_rdata <= mem[c_idx];
            if (state == RESP) begin
                if (op_wr) wr_count <= wr_count + 16'd1;
                else       rd_count <= rd_count + 16'd1;
            end
        end
    end

    // Store is never reset; a request accepted while rst_n is low must not land
    always_ff @(posedge clk) begin
        if (commit && c_wr && rst_n)
            mem[c_idx] <= c_wdata;
    end

endmodule
